// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//
// Result buffer sitting right after the ALU. Each accepted ALU result is stored
// together with its carry-out and a zero flag computed at capture time, and is
// held until the writeback/output stage takes it with a valid/ready handshake.
// The head entry is shown ahead (visible on out_* while out_valid=1).
// All handshake outputs come from registered state only, so neither in_valid
// nor out_ready has a combinational path to any output.
//
// Parameters:
//   WIDTH : ALU result width in bits (default 8)
//   DEPTH : number of entries, power of two, >= 2 (default 4)
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous reset, active-high; wins over push and pop
//   in_valid   : ALU result present this cycle
//   in_result  : ALU result
//   in_carry   : ALU carry-out
//   in_ready   : FIFO can accept (== !full)
//   out_valid  : head entry valid (== !empty)
//   out_result : head result (0 when empty)
//   out_carry  : head carry (0 when empty)
//   out_zero   : head result was zero (0 when empty)
//   out_ready  : consumer accepts head
//   count      : occupied entries, 0..DEPTH
//   full       : count == DEPTH
//   empty      : count == 0
//   drop_count : saturating count of writes refused while full
//                (only when ALU_FIFO_DROP_CNT_EN is defined)
//
// Build option:
//   ALU_FIFO_DROP_CNT_EN : adds the drop_count port and its counter.
// -----------------------------------------------------------------------------
module alu_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_result,
  input  logic                       in_carry,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_result,
  output logic                       out_carry,
  output logic                       out_zero,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
`ifdef ALU_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic             zero;
    logic             carry;
    logic [WIDTH-1:0] result;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          entry_d;
  entry_t          head;
  logic [PW-1:0]   wp_q, wp_d;
  logic [PW-1:0]   rp_q, rp_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  // Status flags derive from the registered count only.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign count     = count_q;

  // A refused write (full) and a pop while empty are both no-ops.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // NOTE: every variable assigned in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    entry_d = '{zero: (in_result == '0), carry: in_carry, result: in_result};

    // Pointers are PW bits wide, so DEPTH-1 -> 0 wraps naturally.
    if (push) wp_d = wp_q + PW'(1);
    if (pop)  rp_d = rp_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because the outputs are masked while empty and reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wp_q] <= entry_d;
  end

  // Show-ahead head: mux of registered storage by registered read pointer.
  assign head       = mem_q[rp_q];
  assign out_result = empty ? '0   : head.result;
  assign out_carry  = empty ? 1'b0 : head.carry;
  assign out_zero   = empty ? 1'b0 : head.zero;

`ifdef ALU_FIFO_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  // Counts every cycle a write is presented while full, saturating at 255.
  always_comb begin
    drop_d = drop_q;
    if (in_valid && full && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_alu_result_fifo
//
// Self-checking bench for alu_result_fifo (WIDTH=8, DEPTH=4). A queue-based
// reference model tracks the expected contents; after every clock edge all
// outputs are compared against it. Directed scenarios cover reset mid-fill,
// ordering and flags, the full and empty boundaries, streaming wrap and drop
// counter saturation, followed by a randomized run with occasional resets.
// Build with +define+ALU_FIFO_DROP_CNT_EN to also check drop_count.
// -----------------------------------------------------------------------------
module tb_alu_result_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_result;
  logic             in_carry;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
`ifdef ALU_FIFO_DROP_CNT_EN
  logic [7:0]       drop_count;
`endif

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_result  (in_result),
    .in_carry   (in_carry),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .empty      (empty)
`ifdef ALU_FIFO_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of stored (result, carry) pairs.
  typedef struct {
    logic [WIDTH-1:0] result;
    logic             carry;
  } item_t;

  item_t model_q[$];
  int    model_drop = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one edge's worth of behaviour to the model, using pre-edge state.
  task automatic model_update(input logic v, input logic [WIDTH-1:0] d, input logic c,
                              input logic ordy, input logic r);
    int  n;
    bit  was_full;
    if (r) begin
      model_q.delete();
      model_drop = 0;
    end else begin
      n        = model_q.size();
      was_full = (n == DEPTH);
      if (v && was_full && model_drop < 255) model_drop++;
      if (n > 0 && ordy) void'(model_q.pop_front());
      if (v && !was_full) model_q.push_back('{result: d, carry: c});
    end
  endtask

  task automatic check_all();
    int               n;
    logic [WIDTH-1:0] er;
    logic             ec;
    n  = model_q.size();
    er = (n > 0) ? model_q[0].result : '0;
    ec = (n > 0) ? model_q[0].carry  : 1'b0;
    check("count",      32'(count),      n);
    check("full",       32'(full),       (n == DEPTH) ? 1 : 0);
    check("empty",      32'(empty),      (n == 0) ? 1 : 0);
    check("in_ready",   32'(in_ready),   (n != DEPTH) ? 1 : 0);
    check("out_valid",  32'(out_valid),  (n != 0) ? 1 : 0);
    check("out_result", 32'(out_result), 32'(er));
    check("out_carry",  32'(out_carry),  32'(ec));
    check("out_zero",   32'(out_zero),   (n > 0 && er == 0) ? 1 : 0);
`ifdef ALU_FIFO_DROP_CNT_EN
    check("drop_count", 32'(drop_count), model_drop);
`endif
  endtask

  // Drive inputs just after an edge, advance one edge, then compare.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic c,
                      input logic ordy, input logic r);
    in_valid  = v;
    in_result = d;
    in_carry  = c;
    out_ready = ordy;
    rst       = r;
    @(posedge clk);
    model_update(v, d, c, ordy, r);
    #1;
    check_all();
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    in_valid  = 1'b0;
    in_result = '0;
    in_carry  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;

    // Reset state.
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_empty",    32'(empty),    1);

    // Reset mid-fill, with a push presented during reset (reset wins).
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 1, 0, 0);
    step(1, 8'h03, 0, 0, 0);
    check("fill3_count", 32'(count), 3);
    step(1, 8'h04, 1, 1, 1);
    check("midrst_count",  32'(count),      0);
    check("midrst_valid",  32'(out_valid),  0);
    check("midrst_result", 32'(out_result), 0);
    step(1, 8'h11, 0, 0, 0);
    check("post_rst_head", 32'(out_result), 32'h11);
    step(0, 8'h00, 0, 1, 0);

    // Order and flags; out_ready ignored while empty is also exercised.
    step(1, 8'h00, 1, 0, 0);
    step(1, 8'h7F, 0, 0, 0);
    step(1, 8'hFF, 1, 0, 0);
    check("ord0_zero",  32'(out_zero),  1);
    check("ord0_carry", 32'(out_carry), 1);
    step(0, 8'h00, 0, 1, 0);
    check("ord1_head", 32'(out_result), 32'h7F);
    check("ord1_zero", 32'(out_zero),   0);
    step(0, 8'h00, 0, 1, 0);
    check("ord2_head",  32'(out_result), 32'hFF);
    check("ord2_carry", 32'(out_carry),  1);
    step(0, 8'h00, 0, 1, 0);
    check("ord_empty", 32'(empty), 1);
    step(0, 8'h00, 0, 1, 0);

    // Fill to full, then a refused write.
    for (int i = 0; i < DEPTH; i++) step(1, 8'hA0 + 8'(i), 0, 0, 0);
    check("full_flag", 32'(full), 1);
    step(1, 8'hAA, 1, 0, 0);
    check("full_count", 32'(count),      DEPTH);
    check("full_head",  32'(out_result), 32'hA0);
`ifdef ALU_FIFO_DROP_CNT_EN
    check("drop_one", 32'(drop_count), 1);
`endif

    // Full with simultaneous pop: pop only, write lands next cycle.
    step(1, 8'h55, 0, 1, 0);
    check("fullpop_count", 32'(count),    3);
    check("fullpop_ready", 32'(in_ready), 1);
    step(1, 8'h55, 0, 0, 0);
    check("fullpop_store", 32'(count), 4);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);
    check("fullpop_last", 32'(out_result), 32'h55);
    step(0, 8'h00, 0, 1, 0);

    // Streaming through the pointer wrap.
    for (int k = 1; k <= 10; k++) begin
      step(1, 8'(k), k[0], 1, 0);
      check("stream_head",  32'(out_result), k);
      check("stream_count", 32'(count),      1);
    end
    step(0, 8'h00, 0, 1, 0);

    // Hold full with a pending write long enough to saturate drop_count.
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 8'hC0 + 8'(i), 1, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 8'hEE, 0, 0, 0);
`ifdef ALU_FIFO_DROP_CNT_EN
    check("drop_sat", 32'(drop_count), 255);
`endif
    step(0, 8'h00, 0, 0, 1);

    // Randomized traffic with occasional resets and frequent zero results.
    for (int i = 0; i < 3000; i++) begin
      d = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
      step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Result buffer directly downstream of the ALU. Captures each ALU result with its carry-out, computes a zero flag at capture, and holds up to DEPTH entries until the consumer (register writeback / output stage) accepts them with a valid/ready handshake. It decouples ALU issue from writeback stalls without back-pressuring the ALU datapath combinationally.

## Interface

**Parameters**
- WIDTH, 8: ALU result width in bits.
- DEPTH, 4: entry count; power of two, ≥ 2.

**Ports**
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: ALU result present this cycle.
- in_result, input, WIDTH: ALU result.
- in_carry, input, 1: ALU carry-out.
- in_ready, output, 1: FIFO can accept; equals !full.
- out_valid, output, 1: head entry valid; equals !empty.
- out_result, output, WIDTH: head result.
- out_carry, output, 1: head carry.
- out_zero, output, 1: head result == 0.
- out_ready, input, 1: consumer accepts head.
- count, output, $clog2(DEPTH)+1: occupied entries, 0..DEPTH.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- drop_count, output, 8: dropped-write counter; present only with ALU_FIFO_DROP_CNT_EN.

## Operation

- Storage: DEPTH entries of {zero, carry, result}, i.e. WIDTH+2 bits each.
- Write pointer wp and read pointer rp are each $clog2(DEPTH) bits and wrap modulo DEPTH (DEPTH−1 → 0).
- push = in_valid & in_ready.
  - On push, store {in_result == 0, in_carry, in_result} at wp, then wp <= wp+1.
- pop = out_valid & out_ready.
  - On pop, rp <= rp+1.
- count update:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- Show-ahead output: out_result, out_carry and out_zero reflect entry[rp] whenever out_valid=1. They are forced to 0 when empty.
- Full boundary: in_ready=0 when full, even if a pop occurs the same cycle. There is no write-through when full. A pop frees a slot, and in_ready rises the next cycle.
- Empty boundary: a push while empty sets out_valid in the next cycle. There is no same-cycle bypass. out_ready is ignored while empty.
- Write while full (in_valid=1, in_ready=0): the data is not stored and no state changes, except drop_count when that feature is enabled.
- Reset (rst=1 at a clock edge), including mid-operation:
  - wp, rp and count go to 0; all entries are discarded.
  - Storage contents need not be cleared, since outputs are masked when empty.
  - Reset has priority over push and pop in the same cycle.
- Reset values:
  - in_ready=1, out_valid=0, out_result=0, out_carry=0, out_zero=0.
  - count=0, full=0, empty=1, drop_count=0.

## Timing

- Input-to-output latency: 1 cycle. A push at edge N makes data visible on out_* after edge N when the FIFO was empty.
- Throughput: 1 push and 1 pop per cycle sustained whenever 0 < count < DEPTH.
- in_ready, out_valid, full, empty and count depend only on registered state. There is no combinational path from in_valid or out_ready to any output.
- out_* data is a mux of registered storage indexed by registered rp.
- A producer may hold in_valid=1 across cycles. Each cycle with in_ready=1 stores one entry.

## Configuration

- ALU_FIFO_DROP_CNT_EN
  - Defined:
    - drop_count port exists.
    - It increments by 1 on every cycle with in_valid=1 and full=1, and saturates at 255.
    - It is cleared only by rst.
  - Undefined:
    - Port and counter are absent.
    - Dropped writes are silently discarded.
    - All other behaviour is identical.

## Test plan

- **Reset mid-fill:** push 3 entries, then assert rst for 1 cycle → count=0, empty=1, out_valid=0, out_result=0, in_ready=1. The next push of 0x11 appears as the head.
- **Order and flags (WIDTH=8):** push {0x00,c=1}, {0x7F,c=0}, {0xFF,c=1} with out_ready=0, then set out_ready=1 → heads appear in order as (0x00,carry=1,zero=1), (0x7F,0,0), (0xFF,1,0). empty=1 after the third pop.
- **Fill to full:** 4 pushes with no pop → full=1, in_ready=0, count=4. A 5th write of 0xAA is not stored and the head stays at the first entry. With the macro defined, drop_count=1.
- **Full with simultaneous pop:** full, in_valid=1 with 0x55, out_ready=1 → that cycle pops only and count=3. The next cycle in_ready=1 and 0x55 is stored, giving count=4.
- **Streaming wrap:** in_valid=1 and out_ready=1 continuously for 10 cycles with data 0x01..0x0A → count holds at 1 after the first cycle. Outputs appear as 0x01..0x0A in order, with pointers wrapping twice and no loss.
- **Drop saturation (macro defined):** hold full with in_valid=1 for 300 cycles → drop_count=255 and stays there until rst.
